reaction_bot: RTL and testbench
===============================

Name: reaction_bot

Overview:
- Automated opponent that plays the reaction-timer game from the player side.
- Watches the game's SIGNAL and FALSE_START outputs and drives an active-low button line wired in place of PLAYER_A or PLAYER_B.
- Reaction delay is programmable in clock cycles; a cheat mode forces a false start.
- Used for self-test of the game FSM and as a single-player opponent.

Parameters:
- DELAY_W, 10, width of the DELAY input and the internal delay counter.
- HOLD_CYCLES, 4, number of cycles PRESS_N is held low per press (must be at least 1).

Ports:
- CLK  input  1  system clock; all state updates on its rising edge.
- RESET  input  1  synchronous, active-low reset (RESET==0 at a rising CLK edge resets the block).
- ENABLE  input  1  bot participates while 1; 0 aborts any pending reaction.
- SIGNAL  input  1  game "go" light; 1 means the player should press.
- FALSE_START  input  1  game false-start indicator.
- CHEAT  input  1  when 1, the bot presses without waiting for SIGNAL.
- DELAY  input  DELAY_W  reaction delay in cycles; sampled once per round.
- PRESS_N  output  1  active-low button drive to the game (1 = released).
- STATE  output  3  current FSM state encoding.
- PRESS_COUNT  output  8  number of presses issued; saturates at 255.

Behaviour:
- Reset (RESET==0 at a CLK edge):
  - STATE=IDLE, PRESS_N=1, PRESS_COUNT=0, both internal counters=0.
  - Reset takes priority over every other input.
  - Reset during PRESS releases PRESS_N (back to 1) after that same edge.
- Outputs are registered Moore outputs:
  - PRESS_N = 0 exactly when STATE==PRESS.
  - STATE is the state register itself.
- State encodings: IDLE=0, ARMED=1, WAIT=2, PRESS=3, COOLDOWN=4. Encodings 5-7 are illegal and go to IDLE on the next edge.
- IDLE:
  - If ENABLE==1 and SIGNAL==0, go to ARMED.
  - Otherwise stay in IDLE. The bot never arms while SIGNAL is already high, so a stale light is never treated as a new round.
- ARMED:
  - ENABLE==0 → IDLE. This takes priority over the next two rules.
  - CHEAT==1 → WAIT, with the delay counter loaded from DELAY.
  - SIGNAL==1 → WAIT, with the delay counter loaded from DELAY.
  - Otherwise stay in ARMED.
  - CHEAT is sampled only in ARMED.
- WAIT:
  - ENABLE==0 → IDLE (abort; no press is issued).
  - Delay counter == 0 → PRESS, with the hold counter loaded with HOLD_CYCLES-1.
  - Otherwise decrement the delay counter.
  - SIGNAL is ignored in WAIT, so a SIGNAL drop does not abort the reaction.
- PRESS:
  - On the edge that enters PRESS, PRESS_COUNT increments (saturating at 255).
  - When the hold counter reaches 0 → COOLDOWN; otherwise decrement it.
  - PRESS_N stays low for exactly HOLD_CYCLES cycles.
  - ENABLE and FALSE_START do not shorten the press.
- COOLDOWN:
  - Stay until SIGNAL==0 and FALSE_START==0 in the same cycle, then go to IDLE.
- Latency:
  - Let edge k be the edge at which ARMED samples SIGNAL==1 (or CHEAT==1).
  - PRESS_N falls after edge k+1+DELAY and rises after edge k+1+DELAY+HOLD_CYCLES.
  - DELAY=0 gives the minimum latency of 2 edges from SIGNAL sampled high to PRESS_N low.
- Arithmetic:
  - DELAY is treated as unsigned; the maximum value 2^DELAY_W-1 is legal.
  - The counters never wrap, because they are only decremented while non-zero.
- Simultaneous events:
  - In ARMED, if ENABLE==0 together with SIGNAL==1, the bot goes to IDLE.
  - In ARMED, if CHEAT==1 and SIGNAL==1 together, the bot goes to WAIT (same result either way).

Test Plan:
- Reset: hold RESET=0 for 2 cycles with arbitrary inputs → PRESS_N=1, STATE=0, PRESS_COUNT=0.
- Normal reaction:
  - ENABLE=1, DELAY=5, SIGNAL low then high, with edge k being the edge that first samples SIGNAL=1.
  - Expect PRESS_N low after edges k+6 through k+9 (4 cycles), then high.
  - PRESS_COUNT=1; STATE=COOLDOWN until SIGNAL=0 and FALSE_START=0, then IDLE and ARMED on following edges.
- Zero delay and stale signal:
  - SIGNAL=1 while in IDLE → bot stays in IDLE.
  - Drop SIGNAL, raise it again with DELAY=0 → PRESS_N low 2 edges after SIGNAL is sampled high.
- Cheat: CHEAT=1, SIGNAL held 0, DELAY=3 → PRESS_N low after edge k+4 with no SIGNAL; COOLDOWN exits only once FALSE_START=0.
- Abort: ENABLE dropped mid-WAIT with DELAY=100 → IDLE on the next edge, PRESS_N never low, PRESS_COUNT unchanged.
- Reset mid-press and saturation:
  - RESET=0 during the 2nd PRESS cycle → PRESS_N=1 after that edge, STATE=IDLE.
  - Run 260 rounds → PRESS_COUNT stays at 255.

Source files
------------

// File: rtl/reaction_bot.sv
`default_nettype none
// ============================================================================
// Module      : reaction_bot
// Description : Automated reaction-game player driving an active-low button.
// Revision    : 1.0 - initial release
// ============================================================================
module reaction_bot #(
    parameter int DELAY_W     = 10,
    parameter int HOLD_CYCLES = 4
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               ENABLE,
    input  logic               SIGNAL,
    input  logic               FALSE_START,
    input  logic               CHEAT,
    input  logic [DELAY_W-1:0] DELAY,
    output logic               PRESS_N,
    output logic [2:0]         STATE,
    output logic [7:0]         PRESS_COUNT
);

    localparam int c_HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_INIT = c_HOLD_W'(HOLD_CYCLES - 1);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_ARMED    = 3'd1;
    localparam logic [2:0] c_WAIT     = 3'd2;
    localparam logic [2:0] c_PRESS    = 3'd3;
    localparam logic [2:0] c_COOLDOWN = 3'd4;

    logic [2:0]          r_state;
    logic                r_press_n;
    logic [7:0]          r_count;
    logic [DELAY_W-1:0]  r_delay;
    logic [c_HOLD_W-1:0] r_hold;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state   <= c_IDLE;
            r_press_n <= 1'b1;
            r_count   <= 8'd0;
            r_delay   <= '0;
            r_hold    <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    // Arming only on a dark light keeps a stale SIGNAL from starting a round.
                    if (ENABLE && !SIGNAL)
                        r_state <= c_ARMED;
                end
                c_ARMED: begin
                    if (!ENABLE) begin
                        r_state <= c_IDLE;
                    end else if (CHEAT || SIGNAL) begin
                        r_state <= c_WAIT;
                        r_delay <= DELAY;
                    end
                end
                c_WAIT: begin
                    if (!ENABLE) begin
                        r_state <= c_IDLE;
                    end else if (r_delay == '0) begin
                        r_state   <= c_PRESS;
                        r_press_n <= 1'b0;
                        r_hold    <= c_HOLD_INIT;
                        if (r_count != 8'hFF)
                            r_count <= r_count + 8'd1;
                    end else begin
                        r_delay <= r_delay - DELAY_W'(1);
                    end
                end
                c_PRESS: begin
                    if (r_hold == '0) begin
                        r_state   <= c_COOLDOWN;
                        r_press_n <= 1'b1;
                    end else begin
                        r_hold <= r_hold - c_HOLD_W'(1);
                    end
                end
                c_COOLDOWN: begin
                    if (!SIGNAL && !FALSE_START)
                        r_state <= c_IDLE;
                end
                default: begin
                    r_state   <= c_IDLE;
                    r_press_n <= 1'b1;
                end
            endcase
        end
    end

    assign PRESS_N     = r_press_n;
    assign STATE       = r_state;
    assign PRESS_COUNT = r_count;

endmodule
`default_nettype wire

// File: tb/tb_reaction_bot.sv
`default_nettype none
// ============================================================================
// Module      : tb_reaction_bot
// Description : Directed + random bench for reaction_bot against a timing model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reaction_bot;

    localparam int DELAY_W = 10;
    localparam int HOLD    = 4;

    logic               CLK = 1'b0;
    logic               RESET = 1'b0;
    logic               ENABLE = 1'b0;
    logic               SIGNAL = 1'b0;
    logic               FALSE_START = 1'b0;
    logic               CHEAT = 1'b0;
    logic [DELAY_W-1:0] DELAY = '0;
    logic               PRESS_N;
    logic [2:0]         STATE;
    logic [7:0]         PRESS_COUNT;

    int checks   = 0;
    int failures = 0;

    // Reference model: tracks the absolute edge numbers at which the press
    // begins and ends, derived from the documented latency rule.
    int n       = 0;
    int m_state = 0;
    int m_count = 0;
    int t_press = 0;
    int t_rel   = 0;

    reaction_bot #(.DELAY_W(DELAY_W), .HOLD_CYCLES(HOLD)) dut (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .SIGNAL(SIGNAL),
        .FALSE_START(FALSE_START), .CHEAT(CHEAT), .DELAY(DELAY),
        .PRESS_N(PRESS_N), .STATE(STATE), .PRESS_COUNT(PRESS_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic model_edge();
        n++;
        if (!RESET) begin
            m_state = 0;
            m_count = 0;
        end else begin
            case (m_state)
                0: if (ENABLE && !SIGNAL) m_state = 1;
                1: begin
                    if (!ENABLE) m_state = 0;
                    else if (CHEAT || SIGNAL) begin
                        m_state = 2;
                        t_press = n + 1 + int'(DELAY);
                    end
                end
                2: begin
                    if (!ENABLE) m_state = 0;
                    else if (n == t_press) begin
                        m_state = 3;
                        t_rel   = n + HOLD;
                        if (m_count < 255) m_count++;
                    end
                end
                3: if (n == t_rel) m_state = 4;
                4: if (!SIGNAL && !FALSE_START) m_state = 0;
                default: m_state = 0;
            endcase
        end
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h (edge %0d)", tag, got, exp, n);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        check("state", 8'(STATE), 8'(m_state));
        check("press_n", 8'(PRESS_N), (m_state == 3) ? 8'd0 : 8'd1);
        check("press_count", PRESS_COUNT, 8'(m_count));
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    initial begin
        // Reset with arbitrary inputs
        RESET = 1'b0; ENABLE = 1'b1; SIGNAL = 1'b1; CHEAT = 1'b1; FALSE_START = 1'b1;
        DELAY = 10'd7;
        steps(2);
        check("reset_press_n", 8'(PRESS_N), 8'd1);
        check("reset_count", PRESS_COUNT, 8'd0);

        // Normal reaction with DELAY=5
        RESET = 1'b1; CHEAT = 1'b0; FALSE_START = 1'b0; SIGNAL = 1'b0; DELAY = 10'd5;
        steps(2);
        SIGNAL = 1'b1;
        steps(12);
        check("normal_count", PRESS_COUNT, 8'd1);
        SIGNAL = 1'b0;
        steps(3);

        // Stale signal while idle, then zero delay
        ENABLE = 1'b0;
        step();
        ENABLE = 1'b1; SIGNAL = 1'b1;
        steps(3);
        check("stale_idle", 8'(STATE), 8'd0);
        SIGNAL = 1'b0; DELAY = 10'd0;
        step();
        SIGNAL = 1'b1;
        steps(7);
        SIGNAL = 1'b0;
        steps(2);

        // Cheat with FALSE_START holding cooldown
        CHEAT = 1'b1; DELAY = 10'd3; FALSE_START = 1'b1;
        steps(12);
        check("cheat_cooldown", 8'(STATE), 8'd4);
        CHEAT = 1'b0; FALSE_START = 1'b0;
        steps(3);

        // Abort mid-wait
        DELAY = 10'd100; SIGNAL = 1'b1;
        steps(10);
        ENABLE = 1'b0;
        step();
        check("abort_idle", 8'(STATE), 8'd0);
        SIGNAL = 1'b0;
        steps(3);
        ENABLE = 1'b1;
        steps(2);

        // Maximum delay
        DELAY = 10'h3FF; SIGNAL = 1'b1;
        steps(1035);
        SIGNAL = 1'b0;
        steps(3);

        // Reset during the second press cycle
        DELAY = 10'd0; SIGNAL = 1'b1;
        for (int i = 0; i < 20 && m_state != 3; i++) step();
        check("reach_press", 8'(STATE), 8'd3);
        step();
        RESET = 1'b0;
        step();
        check("midpress_release", 8'(PRESS_N), 8'd1);
        check("midpress_idle", 8'(STATE), 8'd0);
        RESET = 1'b1; SIGNAL = 1'b0;
        steps(2);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            RESET       = ($urandom_range(0, 59) != 0);
            ENABLE      = ($urandom_range(0, 9) != 0);
            SIGNAL      = 1'($urandom_range(0, 1));
            FALSE_START = ($urandom_range(0, 3) == 0);
            CHEAT       = ($urandom_range(0, 7) == 0);
            DELAY       = DELAY_W'($urandom_range(0, 6));
            step();
        end

        // Saturation: 260 full rounds
        RESET = 1'b1; ENABLE = 1'b1; CHEAT = 1'b0; FALSE_START = 1'b0; SIGNAL = 1'b0;
        steps(20);
        for (int r = 0; r < 260; r++) begin
            DELAY  = DELAY_W'($urandom_range(0, 2));
            SIGNAL = 1'b1;
            steps(9);
            SIGNAL = 1'b0;
            steps(2);
        end
        check("saturated", PRESS_COUNT, 8'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
